inst_sram_responder: RTL and testbench
======================================

// Module: inst_sram_responder
// PURPOSE
//   Responder (slave) end of the fetch-stage instruction SRAM port (en/we/addr/wdata).
//   Word-organised synchronous memory with a configurable read latency, an address-range check,
//   an error flag and a read-request counter.
//   Sits between the Fetch stage and the instruction store.
//   Used as the bench/FPGA instruction memory behind the Fetch stage.
// PARAMETERS
//   ADDR_BASE    32'h1c00_0000  physical byte address of word 0
//   DEPTH_WORDS  4096           number of 32-bit words; power of two
//   RD_LAT       1              read latency in cycles; legal range 1..4
// PORTS
//   clk              in   1   clock; all state updates on the rising edge
//   rstn             in   1   reset; asynchronous, active-low
//   inst_sram_en     in   1   request valid this cycle
//   inst_sram_we     in   4   byte write enables; 4'b0 = read
//   inst_sram_addr   in   32  physical byte address
//   inst_sram_wdata  in   32  write data; byte i = bits [8i+7:8i]
//   inst_sram_rdata  out  32  read data
//   inst_sram_rvalid out  1   rdata/rerr valid; one-cycle pulse per accepted read
//   inst_sram_rerr   out  1   accepted read was out of range or misaligned
//   req_cnt          out  32  count of accepted reads, saturating
// BEHAVIOUR
//   Decode
//   - idx = (addr - ADDR_BASE) >> 2.
//   - in_range = (addr >= ADDR_BASE) && (idx < DEPTH_WORDS); compare on full 32 bits, no wrap.
//   - misaligned = |addr[1:0].
//   Accept rules
//   - en=1, we=0: read accepted, regardless of range.
//   - en=1, we!=0: write; no rvalid and no req_cnt change.
//   - en=0: nothing; we, addr and wdata are ignored.
//   - No backpressure: one request is accepted every cycle.
//   Write
//   - Requires en & |we & in_range & !misaligned.
//   - At the clock edge, each byte lane with we[i]=1 is updated; other lanes keep their value.
//   - An illegal write is silently dropped: no memory change, no error output.
//   Read pipeline
//   - Accepted read in cycle N: array sampled at edge N.
//   - rvalid=1 in cycle N+RD_LAT, for exactly one cycle.
//   - Fully pipelined: back-to-back reads give back-to-back rvalid, in order.
//   - Data is captured at the acceptance edge; a later write to the same word does not alter an in-flight read.
//   - Legal read: rdata = mem[idx], rerr = 0.
//   - Illegal read (out of range or misaligned): rdata = 32'h0, rerr = 1, rvalid still 1.
//   - When rvalid=0, rdata holds its last value and rerr = 0.
//   Counter
//   - req_cnt += 1 per accepted read.
//   - Saturates at 32'hffff_ffff; never wraps.
//   Reset (rstn=0)
//   - Immediately: rdata=0, rvalid=0, rerr=0, req_cnt=0; all pipeline stages are cleared.
//   - Reads in flight when reset asserts are dropped and never produce rvalid.
//   - Memory array contents are not reset and are preserved across reset.
//   - The first request is sampled on the first rising edge with rstn=1.
//   Elaboration
//   - RD_LAT outside 1..4, or DEPTH_WORDS not a power of two: stop elaboration with $error.
// TESTING
//   T1 write, then read:
//      write addr=1c00_0000, we=f, wdata=0200_0000; then read the same address
//      -> RD_LAT cycles later: rvalid=1, rdata=0200_0000, rerr=0, req_cnt=1.
//   T2 byte write:
//      mem word = 1122_3344; write we=4'b0101, wdata=aabb_ccdd; read back
//      -> rdata = 11bb_33dd.
//   T3 streaming, RD_LAT=3:
//      reads of 1c00_0000/04/08/0c on consecutive cycles
//      -> 4 consecutive rvalid cycles starting 3 cycles after the first read, in order.
//   T4 illegal reads:
//      read 1bff_fffc; read 1c00_0002; read ADDR_BASE + 4*DEPTH_WORDS
//      -> each gives rvalid=1, rerr=1, rdata=0.
//      write 1bff_fffc -> memory unchanged, no rvalid.
//   T5 reset mid-flight, RD_LAT=4:
//      two reads in flight, pull rstn low between clock edges
//      -> outputs are 0 at once, no rvalid after release, memory keeps the written data.
//   T6 read then write, same word:
//      read word A, write A on the next cycle
//      -> the returned data is the old value.
//      counter forced to ffff_fffe, then 3 reads -> req_cnt stays at ffff_ffff.

Source files
------------

// File: rtl/inst_sram_if.sv
// Fetch-side instruction SRAM port: request (en/we/addr/wdata) and read response (rdata/rvalid/rerr).
// Handshake: no ready signal; every cycle with inst_sram_en=1 is accepted, and each accepted read
// returns exactly one inst_sram_rvalid pulse RD_LAT cycles later, in request order.
interface inst_sram_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_rvalid;
  logic        inst_sram_rerr;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata, inst_sram_rvalid, inst_sram_rerr
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata, inst_sram_rvalid, inst_sram_rerr
  );
endinterface

// File: rtl/inst_sram_responder.sv
// Instruction SRAM responder: byte-writable word memory, fixed-latency pipelined reads with
// range/alignment error reporting and a saturating accepted-read counter.
module inst_sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h1c00_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rstn,
  inst_sram_if.slave  bus,
  output logic [31:0] req_cnt
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  if ((RD_LAT < 1) || (RD_LAT > 4) || (DEPTH_WORDS < 1) ||
      ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) || (ADDR_BASE[1:0] != 2'b00)) begin : g_bad_params
    $error("inst_sram_responder: RD_LAT must be 1..4, DEPTH_WORDS a power of two, ADDR_BASE word aligned");
  end

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   word_off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          misaligned;
  logic          rd_acc;
  logic          rd_bad;
  logic          wr_ok;
  logic [31:0]   rd_word;

  // Word offset from the base; the >= test keeps addresses below the base from wrapping into range.
  assign word_off   = bus.inst_sram_addr[31:2] - ADDR_BASE[31:2];
  assign idx        = word_off[AW-1:0];
  assign in_range   = (bus.inst_sram_addr >= ADDR_BASE) && ({2'b00, word_off} < DEPTH32);
  assign misaligned = |bus.inst_sram_addr[1:0];
  assign rd_acc     = bus.inst_sram_en && (bus.inst_sram_we == 4'b0000);
  assign rd_bad     = !in_range || misaligned;
  assign wr_ok      = bus.inst_sram_en && (|bus.inst_sram_we) && !rd_bad;
  assign rd_word    = rd_bad ? 32'h0 : mem[idx];

  // Memory contents are deliberately outside the reset domain so they survive rstn.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.inst_sram_we[i]) mem[idx][8*i +: 8] <= bus.inst_sram_wdata[8*i +: 8];
      end
    end
  end

  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pe;
  logic [31:0]       pd [RD_LAT];

  // Data/err stages only load behind a valid entry, so the last stage holds the previous response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
      pe <= '0;
      for (int k = 0; k < RD_LAT; k++) pd[k] <= 32'h0;
    end else begin
      pv[0] <= rd_acc;
      if (rd_acc) begin
        pd[0] <= rd_word;
        pe[0] <= rd_bad;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) begin
          pd[k] <= pd[k-1];
          pe[k] <= pe[k-1];
        end
      end
    end
  end

  assign bus.inst_sram_rvalid = pv[RD_LAT-1];
  assign bus.inst_sram_rerr   = pv[RD_LAT-1] & pe[RD_LAT-1];
  assign bus.inst_sram_rdata  = pd[RD_LAT-1];

  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 32'h0;
    end else if (rd_acc && (cnt_q != 32'hffff_ffff)) begin
      cnt_q <= cnt_q + 32'h1;
    end
  end

  assign req_cnt = cnt_q;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: three instances (RD_LAT 1, 3, 4) driven in lockstep, with a
// reference memory and per-instance queues of expected responses tagged with their due cycle.
module tb_inst_sram_responder;
  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam int          DEPTH = 4096;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  inst_sram_if b1 ();
  inst_sram_if b3 ();
  inst_sram_if b4 ();
  logic [31:0] cnt1, cnt3, cnt4;

  inst_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(1)) u1 (
    .clk(clk), .rstn(rstn), .bus(b1.slave), .req_cnt(cnt1));
  inst_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(3)) u3 (
    .clk(clk), .rstn(rstn), .bus(b3.slave), .req_cnt(cnt3));
  inst_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(4)) u4 (
    .clk(clk), .rstn(rstn), .bus(b4.slave), .req_cnt(cnt4));

  int          lat_tab [3] = '{1, 3, 4};
  logic        rv [3];
  logic        re [3];
  logic [31:0] rd [3];
  logic [31:0] cnt [3];

  always_comb begin
    rv[0] = b1.inst_sram_rvalid; re[0] = b1.inst_sram_rerr; rd[0] = b1.inst_sram_rdata; cnt[0] = cnt1;
    rv[1] = b3.inst_sram_rvalid; re[1] = b3.inst_sram_rerr; rd[1] = b3.inst_sram_rdata; cnt[1] = cnt3;
    rv[2] = b4.inst_sram_rvalid; re[2] = b4.inst_sram_rerr; rd[2] = b4.inst_sram_rdata; cnt[2] = cnt4;
  end

  // Entry layout: {due_cycle[31:0], err, data[31:0]}
  logic [64:0] exp_q [3][$];
  logic [31:0] last_rd [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] exp_cnt = 32'h0;
  logic [31:0] model_mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input logic en, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    b1.inst_sram_en = en; b1.inst_sram_we = we; b1.inst_sram_addr = addr; b1.inst_sram_wdata = wdata;
    b3.inst_sram_en = en; b3.inst_sram_we = we; b3.inst_sram_addr = addr; b3.inst_sram_wdata = wdata;
    b4.inst_sram_en = en; b4.inst_sram_we = we; b4.inst_sram_addr = addr; b4.inst_sram_wdata = wdata;
  endtask

  // One request per call; the request is sampled at the following rising edge.
  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic [31:0] idx;
    logic [31:0] word;
    logic        legal;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("req_cnt_l%0d", lat_tab[d]), cnt[d], exp_cnt);
    set_bus(en, we, addr, wdata);
    idx   = (addr - BASE) >> 2;
    legal = (addr >= BASE) && (idx < 32'(DEPTH)) && (addr[1:0] == 2'b00);
    if (en && (we == 4'b0000)) begin
      word = legal ? model_mem[idx] : 32'h0;
      for (int d = 0; d < 3; d++) exp_q[d].push_back({32'(cyc + lat_tab[d]), ~legal, word});
      if (exp_cnt != 32'hffff_ffff) exp_cnt = exp_cnt + 32'h1;
    end else if (en && legal) begin
      word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (we[i]) word[8*i +: 8] = wdata[8*i +: 8];
      model_mem[idx] = word;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
  endtask

  task automatic rd_req(input logic [31:0] addr);
    drive(1'b1, 4'b0000, addr, $urandom);
  endtask

  task automatic wr_req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    drive(1'b1, we, addr, wdata);
  endtask

  // Response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [64:0] e;
    for (int d = 0; d < 3; d++) begin
      if (rv[d]) begin
        if (exp_q[d].size() == 0) begin
          check($sformatf("unexpected_rvalid_l%0d", lat_tab[d]), 32'(rv[d]), 32'h0);
        end else begin
          e = exp_q[d].pop_front();
          check($sformatf("rdata_l%0d", lat_tab[d]), rd[d], e[31:0]);
          check($sformatf("rerr_l%0d", lat_tab[d]), 32'(re[d]), 32'(e[32]));
          check($sformatf("latency_l%0d", lat_tab[d]), 32'(cyc), e[64:33]);
        end
        last_rd[d] = rd[d];
      end else begin
        check($sformatf("rerr_idle_l%0d", lat_tab[d]), 32'(re[d]), 32'h0);
        check($sformatf("rdata_hold_l%0d", lat_tab[d]), rd[d], last_rd[d]);
        if ((exp_q[d].size() != 0) && (exp_q[d][0][64:33] == 32'(cyc))) begin
          check($sformatf("missing_rvalid_l%0d", lat_tab[d]), 32'(rv[d]), 32'h1);
          void'(exp_q[d].pop_front());
        end
      end
    end
  end

  initial begin
    set_bus(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_rvalid_l%0d", lat_tab[d]), 32'(rv[d]), 32'h0);
      check($sformatf("reset_rerr_l%0d", lat_tab[d]), 32'(re[d]), 32'h0);
      check($sformatf("reset_rdata_l%0d", lat_tab[d]), rd[d], 32'h0);
      check($sformatf("reset_cnt_l%0d", lat_tab[d]), cnt[d], 32'h0);
    end
    @(negedge clk);
    #2 rstn = 1'b1;

    // T1: full-word write then read back
    wr_req(4'hf, 32'h1c00_0000, 32'h0200_0000);
    rd_req(32'h1c00_0000);
    idle(5);

    // T2: byte-lane write merges into the existing word
    wr_req(4'hf, 32'h1c00_0004, 32'h1122_3344);
    wr_req(4'b0101, 32'h1c00_0004, 32'haabb_ccdd);
    rd_req(32'h1c00_0004);
    idle(5);

    // T3: back-to-back streaming reads
    wr_req(4'hf, 32'h1c00_0008, $urandom);
    wr_req(4'hf, 32'h1c00_000c, $urandom);
    rd_req(32'h1c00_0000);
    rd_req(32'h1c00_0004);
    rd_req(32'h1c00_0008);
    rd_req(32'h1c00_000c);
    idle(6);

    // T4: illegal writes must not alias onto words 4095 or 0; illegal reads flag rerr
    wr_req(4'hf, 32'h1c00_3ffc, 32'h5a5a_a5a5);
    wr_req(4'hf, 32'h1bff_fffc, 32'hdead_beef);
    wr_req(4'hf, 32'h1c00_0002, 32'hdead_beef);
    wr_req(4'hf, BASE + 32'(4 * DEPTH), 32'hdead_beef);
    rd_req(32'h1bff_fffc);
    rd_req(32'h1c00_0002);
    rd_req(BASE + 32'(4 * DEPTH));
    rd_req(32'h1c00_3ffc);
    rd_req(32'h1c00_0000);
    idle(6);

    // T5: reset with reads in flight
    rd_req(32'h1c00_0004);
    rd_req(32'h1c00_0008);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    set_bus(1'b0, 4'h0, 32'h0, 32'h0);
    for (int d = 0; d < 3; d++) begin
      exp_q[d].delete();
      last_rd[d] = 32'h0;
    end
    exp_cnt = 32'h0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("midreset_rvalid_l%0d", lat_tab[d]), 32'(rv[d]), 32'h0);
      check($sformatf("midreset_rerr_l%0d", lat_tab[d]), 32'(re[d]), 32'h0);
      check($sformatf("midreset_rdata_l%0d", lat_tab[d]), rd[d], 32'h0);
      check($sformatf("midreset_cnt_l%0d", lat_tab[d]), cnt[d], 32'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    idle(6);
    rd_req(32'h1c00_0004);
    rd_req(32'h1c00_000c);
    idle(6);

    // T6: a write right after a read must not change the in-flight data
    rd_req(32'h1c00_0008);
    wr_req(4'hf, 32'h1c00_0008, 32'h7777_1234);
    rd_req(32'h1c00_0008);
    idle(6);

    // Counter saturation from ffff_fffe
    @(negedge clk);
    #1;
    force u1.cnt_q = 32'hffff_fffe;
    force u3.cnt_q = 32'hffff_fffe;
    force u4.cnt_q = 32'hffff_fffe;
    exp_cnt = 32'hffff_fffe;
    #1;
    release u1.cnt_q;
    release u3.cnt_q;
    release u4.cnt_q;
    rd_req(32'h1c00_0000);
    rd_req(32'h1c00_0004);
    rd_req(32'h1c00_0008);
    idle(6);

    for (int d = 0; d < 3; d++)
      check($sformatf("queue_drained_l%0d", lat_tab[d]), 32'(exp_q[d].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
